// File: rtl/rj_pkg.sv
// Shared definitions for the ring/Johnson shift counter: mode encoding,
// per-edge action encoding and the seed / sequence-length helpers.
package rj_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } rj_mode_e;

    // What the counter does on a given edge, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_SHIFT,
        ACT_FIX,
        ACT_LOAD,
        ACT_MODE
    } rj_act_e;

    localparam int RJ_MAX_W = 32;

    // Seed is returned at the maximum width; callers size-cast it to their WIDTH.
    function automatic logic [RJ_MAX_W-1:0] rj_seed(input rj_mode_e m);
        return (m == MODE_RING) ? RJ_MAX_W'(1) : '0;
    endfunction

    function automatic int rj_last_phase(input rj_mode_e m, input int width);
        return (m == MODE_RING) ? (width - 1) : (2 * width - 1);
    endfunction

endpackage

// File: rtl/rj_legal_chk.sv
// Combinational legality check and phase decode of a counter pattern,
// interpreted in either ring or Johnson mode.
module rj_legal_chk
    import rj_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] val_i,
    input  rj_mode_e         mode_i,
    output logic             legal_o,
    output logic [PW-1:0]    phase_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] inv;
    int               ones;
    int               ring_idx;
    int               john_ph;
    logic             low_run;
    logic             high_run;

    assign inv = ~val_i;

    // A run of ones anchored at bit 0 has no carry overlap with val+1;
    // a run anchored at the MSB is the same test on the inverted value.
    assign low_run  = ((val_i & (val_i + ONE)) == '0);
    assign high_run = ((inv & (inv + ONE)) == '0);

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        ones     = 0;
        ring_idx = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (val_i[i]) begin
                ones     = ones + 1;
                ring_idx = i;
            end
        end
        john_ph = val_i[WIDTH-1] ? (2 * WIDTH - ones) : ones;

        legal_o = 1'b0;
        phase_o = '0;
        if (mode_i == MODE_RING) begin
            legal_o = (ones == 1);
            phase_o = PW'(ring_idx);
        end else begin
            legal_o = low_run || high_run;
            phase_o = PW'(john_ph);
        end
    end

endmodule

// File: rtl/rj_shift_counter.sv
// Ring / Johnson shift counter with parallel load, direction control,
// illegal-state self-correction and registered wrap / error pulses.
module rj_shift_counter
    import rj_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    rj_mode_e         mode_q;
    rj_mode_e         mode_in;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] seed;
    logic [PW-1:0]    last_phase;
    rj_act_e          act;

    logic             q_legal;
    logic [PW-1:0]    q_phase;
    logic             lv_legal;
    logic [PW-1:0]    unused_lv_phase;

    assign mode_in    = rj_mode_e'(mode);
    assign seed       = WIDTH'(rj_seed(mode_in));
    assign last_phase = PW'(rj_last_phase(mode_q, WIDTH));

    rj_legal_chk #(.WIDTH(WIDTH), .PW(PW)) u_q_chk (
        .val_i   (cnt_q),
        .mode_i  (mode_q),
        .legal_o (q_legal),
        .phase_o (q_phase)
    );

    // Load legality only matters when the mode is unchanged, so mode_q is the right reference.
    rj_legal_chk #(.WIDTH(WIDTH), .PW(PW)) u_lv_chk (
        .val_i   (load_val),
        .mode_i  (mode_q),
        .legal_o (lv_legal),
        .phase_o (unused_lv_phase)
    );

    always_comb begin
        if (mode_in != mode_q) begin
            act = ACT_MODE;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (!q_legal) begin
            act = ACT_FIX;
        end else if (en) begin
            act = ACT_SHIFT;
        end else begin
            act = ACT_HOLD;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        unique case (act)
            ACT_MODE: cnt_d = seed;
            ACT_LOAD: begin
                cnt_d = lv_legal ? load_val : seed;
                err_d = !lv_legal;
            end
            ACT_FIX: begin
                cnt_d = seed;
                err_d = 1'b1;
            end
            ACT_SHIFT: begin
                unique case ({mode_q, dir})
                    {MODE_RING, 1'b1}:    cnt_d = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
                    {MODE_RING, 1'b0}:    cnt_d = {cnt_q[0], cnt_q[WIDTH-1:1]};
                    {MODE_JOHNSON, 1'b1}: cnt_d = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
                    default:              cnt_d = {~cnt_q[0], cnt_q[WIDTH-1:1]};
                endcase
                // The state is legal here, so the current phase alone predicts the wrap.
                wrap_d = dir ? (q_phase == last_phase) : (q_phase == '0);
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        mode_q <= mode_in;
        if (rst) begin
            cnt_q  <= seed;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q     = cnt_q;
    assign phase = q_phase;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: doc/rj_shift_counter.md
RJ_SHIFT_COUNTER -- requirements
Module: rj_shift_counter

Interface
REQ-001 Parameter WIDTH, default 4, number of counter stages; legal range 2..32.
REQ-002 Parameter PW, default $clog2(2*WIDTH), width of the phase output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  advance enable: one shift per clock while high.
REQ-006 mode  input  1  0 = ring counter, 1 = Johnson (twisted-ring) counter.
REQ-007 dir  input  1  1 = up (shift toward MSB), 0 = down (shift toward LSB).
REQ-008 load  input  1  parallel-load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 q  output  WIDTH  counter state, registered.
REQ-011 phase  output  PW  position of q in the current sequence, combinational decode of q.
REQ-012 wrap  output  1  one-cycle pulse, registered, marks a sequence wrap.
REQ-013 err  output  1  one-cycle pulse, registered, marks an illegal load or illegal-state correction.

Function
REQ-014 Seed pattern SHALL be {0..0,1} in ring mode and all-zeros in Johnson mode.
REQ-015 Ring up SHALL rotate left: q <= {q[W-2:0], q[W-1]}; ring down SHALL rotate right.
REQ-016 Johnson up SHALL be q <= {q[W-2:0], ~q[W-1]}; Johnson down SHALL be q <= {~q[0], q[W-1:1]}.
REQ-017 Ring legality SHALL be exactly one bit set; Johnson legality SHALL be one contiguous run of ones anchored at bit 0 or bit W-1, including all-zeros and all-ones.
REQ-018 Ring phase SHALL be the index of the set bit (0..W-1).
REQ-019 Johnson phase SHALL be popcount(q) when q[W-1]=0, else 2W-popcount(q) (0..2W-1).
REQ-020 The registered mode SHALL be compared with the mode input on every edge; on a mismatch, q SHALL take the new mode's seed and the mode register SHALL update.
REQ-021 Per-edge priority SHALL be: rst > mode change > load > illegal-state correction > en shift > hold.
REQ-022 A load with a legal load_val SHALL set q=load_val; a load with an illegal load_val SHALL set q=seed and err=1.
REQ-023 If q is illegal and no higher-priority event occurs, q SHALL become seed and err SHALL be 1 on the next edge.
REQ-024 wrap SHALL be 1 in the cycle after an en shift that moves phase from last to 0 (up) or from 0 to last (down); otherwise 0.
REQ-025 wrap and err SHALL be 0 after any edge without their triggering event, and SHALL never be held longer than one cycle.
REQ-026 With en=0 and no other event, q SHALL hold.
REQ-027 A dir change SHALL take effect on the next shift with no extra latency.

Reset
REQ-028 While rst=1 at an edge: q=seed of the current mode input, the mode register loads mode, wrap=0, err=0.
REQ-029 rst SHALL override load, en and mode change in the same cycle; there SHALL be no asynchronous reset path.

Structure
REQ-030 A shared package rj_pkg SHALL hold MODE_RING=1'b0, MODE_JOHNSON=1'b1 and the seed functions.
REQ-031 Sub-module rj_legal_chk (combinational) SHALL compute legality and phase from q/load_val and mode; it SHALL be instantiated for q and for load_val.

Verification (WIDTH=4)
REQ-032 Ring up: rst, mode=0, dir=1, en=1 for 5 cycles -> q 0001,0010,0100,1000,0001; wrap=1 the cycle after the return to 0001.
REQ-033 Johnson up: mode=1, en=1 for 8 cycles from 0000 -> 0001,0011,0111,1111,1110,1100,1000,0000; phase 1..7 then 0; one wrap pulse.
REQ-034 Johnson down from 0000, dir=0 -> 1000 then 1100; phase 7 then 6; wrap=1 after the first shift.
REQ-035 Ring, load=1 with load_val=0101 -> q=0001, err=1 for exactly one cycle; load_val=0100 -> q=0100, err=0.
REQ-036 Ring at 0100, mode set to 1 with en=1 -> next q=0000, phase=0, no wrap; counting resumes 0001 on the following edge.
REQ-037 rst=1 together with load=1, load_val=1000 and en=1 -> q=seed, wrap=0, err=0.
